// File: rtl/fx2_slavefifo_wr_ctrl_pkg.sv
// Shared types and constants for the FX2LP slave-FIFO write path.
package fx2_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    GAP    = 3'd3,
    PKTEND = 3'd4
  } fx2_state_t;

  localparam int         FX2_PKT_DEFAULT = 512;
  localparam logic [1:0] FIFOADR_EP2     = 2'b00;

endpackage

// File: rtl/fx2_slavefifo_wr_ctrl_rate_div.sv
// Sample-rate divider: one-cycle strobe every max(decim,1) cycles while enabled.
module fx2_rate_div #(
  parameter int DIV_W = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [DIV_W-1:0] decim,
  output logic             strobe
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_last;

  always_comb begin
    div_last = (decim == '0) ? '0 : decim - DIV_W'(1);
    strobe   = en && (div_cnt == div_last);
  end

  // ">=" so a count stranded above a freshly shrunk decim wraps instead of running to overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        div_cnt <= '0;
    else if (!en || div_cnt >= div_last) div_cnt <= '0;
    else                                 div_cnt <= div_cnt + DIV_W'(1);
  end

endmodule

// File: rtl/fx2_slavefifo_wr_ctrl.sv
// FX2LP slave-FIFO write sequencer for the ADC stream (one-sample hold, short-packet PKTEND).
// Build option FX2_TEST_PATTERN_EN: hold loads an 8-bit ramp instead of the ADC sample.
module fx2_slavefifo_wr_ctrl
  import fx2_pkg::*;
#(
  parameter int DIV_W = 26,
  parameter int PKT_W = 10,
  parameter int OVF_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [DIV_W-1:0] decim,
  input  logic [PKT_W-1:0] pkt_len,
  input  logic [7:0]       sample,
  input  logic             flagn_full,
  output logic [7:0]       fd,
  output logic             slwrn,
  output logic             pktendn,
  output logic             sloen,
  output logic             slrdn,
  output logic [1:0]       fifoadr,
  output logic             busy,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic [2:0]       state_dbg
);

  // Write handshake: a byte moves when hold_valid & flagn_full in RUN/DRAIN;
  // the pins show it one cycle later (slwrn low for exactly one cycle, fd = byte).
  fx2_state_t       state, state_nx;
  logic             strobe;
  logic             wr_go;
  logic             load_hold;
  logic             drop;
  logic [7:0]       hold;
  logic [7:0]       hold_src;
  logic             hold_valid;
  logic [PKT_W-1:0] byte_cnt;
  logic [PKT_W-1:0] pkt_last;

  assign sloen     = 1'b1;
  assign slrdn     = 1'b1;
  assign fifoadr   = FIFOADR_EP2;
  assign state_dbg = state;
  assign pkt_last  = (pkt_len == '0) ? PKT_W'(FX2_PKT_DEFAULT - 1) : pkt_len - PKT_W'(1);

  fx2_rate_div #(.DIV_W(DIV_W)) u_rate_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state == RUN),
    .decim   (decim),
    .strobe  (strobe)
  );

`ifdef FX2_TEST_PATTERN_EN
  logic [7:0] ramp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       ramp <= '0;
    else if (load_hold) ramp <= ramp + 8'd1;
  end

  assign hold_src = ramp;
`else
  assign hold_src = sample;
`endif

  always_comb begin
    wr_go     = hold_valid && flagn_full && (state == RUN || state == DRAIN);
    // a write frees the hold on the same edge, so a coincident strobe is never lost
    load_hold = strobe && (!hold_valid || wr_go);
    drop      = strobe && hold_valid && !wr_go;
    state_nx  = state;
    case (state)
      IDLE:    if (run) state_nx = RUN;
      RUN:     if (!run) state_nx = DRAIN;
      DRAIN:   if (!hold_valid) state_nx = (byte_cnt != '0) ? GAP : IDLE;
      GAP:     state_nx = PKTEND;
      PKTEND:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_valid <= 1'b0;
      byte_cnt   <= '0;
      ovf_cnt    <= '0;
      fd         <= '0;
      slwrn      <= 1'b1;
      pktendn    <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state   <= state_nx;
      busy    <= (state_nx != IDLE);
      slwrn   <= !wr_go;
      pktendn <= (state_nx != PKTEND);
      if (wr_go) fd <= hold;

      if (load_hold) begin
        hold       <= hold_src;
        hold_valid <= 1'b1;
      end else if (wr_go) begin
        hold_valid <= 1'b0;
      end

      if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + OVF_W'(1);

      // full packets are auto-committed by the FX2, so the count simply wraps
      if (state == PKTEND)  byte_cnt <= '0;
      else if (wr_go)       byte_cnt <= (byte_cnt == pkt_last) ? '0 : byte_cnt + PKT_W'(1);
    end
  end

endmodule

// File: tb/tb_fx2_slavefifo_wr_ctrl.sv
// Directed bench for fx2_slavefifo_wr_ctrl: vector table of stream runs plus stall/decim/reset sequences.
module tb_fx2_slavefifo_wr_ctrl;
  import fx2_pkg::*;

  localparam int DIV_W = 26;
  localparam int PKT_W = 10;
  localparam int OVF_W = 16;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             run;
  logic [DIV_W-1:0] decim;
  logic [PKT_W-1:0] pkt_len;
  logic [7:0]       sample;
  logic             flagn_full;
  logic [7:0]       fd;
  logic             slwrn;
  logic             pktendn;
  logic             sloen;
  logic             slrdn;
  logic [1:0]       fifoadr;
  logic             busy;
  logic [OVF_W-1:0] ovf_cnt;
  logic [2:0]       state_dbg;

  fx2_slavefifo_wr_ctrl #(.DIV_W(DIV_W), .PKT_W(PKT_W), .OVF_W(OVF_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .decim      (decim),
    .pkt_len    (pkt_len),
    .sample     (sample),
    .flagn_full (flagn_full),
    .fd         (fd),
    .slwrn      (slwrn),
    .pktendn    (pktendn),
    .sloen      (sloen),
    .slrdn      (slrdn),
    .fifoadr    (fifoadr),
    .busy       (busy),
    .ovf_cnt    (ovf_cnt),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset;
    reset_n    = 1'b0;
    run        = 1'b0;
    flagn_full = 1'b1;
    decim      = DIV_W'(1);
    pkt_len    = PKT_W'(512);
    sample     = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int n_wr, n_pkt, first_wr_cyc, last_wr_cyc, pkt_cyc, busy_fall_cyc, exp_gap, gap_err;

  task automatic clear_mon;
    exp_q.delete();
    n_wr = 0; n_pkt = 0; gap_err = 0; exp_gap = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; pkt_cyc = -1; busy_fall_cyc = -1;
  endtask

  always @(negedge clk) begin
    if (!slwrn) begin
      if (exp_gap > 0 && last_wr_cyc >= 0 && (cyc - last_wr_cyc) != exp_gap) gap_err++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      n_wr++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fd_extra: got write of %0h expected no write (t=%0t)", fd, $time);
      end else begin
        check("fd", fd, exp_q.pop_front());
      end
    end
    if (!pktendn) begin
      n_pkt++;
      pkt_cyc = cyc;
      if (!slwrn) check("slwrn_pktendn_overlap", 1, 0);
    end
    if (!busy && n_pkt > 0 && busy_fall_cyc < 0) busy_fall_cyc = cyc;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain_timeout_busy", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  // Runs exactly nstb strobes: run drops during the cycle of the last strobe.
  task automatic stream(input int dcm, input int plen, input int nstb);
    int d_eff;
    d_eff      = (dcm == 0) ? 1 : dcm;
    decim      = DIV_W'(dcm);
    pkt_len    = PKT_W'(plen);
    flagn_full = 1'b1;
    exp_gap    = d_eff;
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    for (int k = 0; k < nstb * d_eff; k++) begin
      #1 sample = 8'(k * 29 + 7);
      if ((k % d_eff) == d_eff - 1) exp_q.push_back(sample);
      if (k == nstb * d_eff - 1) run = 1'b0;
      @(posedge clk);
    end
  endtask

  typedef struct {
    int dcm;
    int plen;
    int nstb;
    int exp_wr;
    int exp_pkt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int e0;

    vecs[0] = '{4,   512, 2048, 2048, 0};
    vecs[1] = '{2,   512,  100,  100, 1};
    vecs[2] = '{1,   512,  512,  512, 0};
    vecs[3] = '{0,     0,  300,  300, 1};
    vecs[4] = '{3,    16,   40,   40, 1};
    vecs[5] = '{1,     8,   24,   24, 0};
    vecs[6] = '{5,     1,    7,    7, 0};

    clear_mon();
    do_reset();
    check("rst_fd",      fd, 0);
    check("rst_slwrn",   slwrn, 1);
    check("rst_pktendn", pktendn, 1);
    check("rst_busy",    busy, 0);
    check("rst_ovf",     ovf_cnt, 0);
    check("rst_sloen",   sloen, 1);
    check("rst_slrdn",   slrdn, 1);
    check("rst_fifoadr", fifoadr, 0);
    check("rst_state",   state_dbg, 0);

    // ---- table-driven stream runs ----
    for (int v = 0; v < 7; v++) begin
      do_reset();
      clear_mon();
      stream(vecs[v].dcm, vecs[v].plen, vecs[v].nstb);
      wait_idle(100);
      check("vec_writes",   n_wr, vecs[v].exp_wr);
      check("vec_pktend",   n_pkt, vecs[v].exp_pkt);
      check("vec_q_empty",  exp_q.size(), 0);
      check("vec_ovf",      ovf_cnt, 0);
      check("vec_wr_gap",   gap_err, 0);
      if (vecs[v].exp_pkt != 0) begin
        check("vec_idle_before_pktend", pkt_cyc - last_wr_cyc, 2);
        check("vec_busy_fall",          busy_fall_cyc - pkt_cyc, 1);
      end
    end

    // ---- stall: flag low 10 cycles from the first RUN cycle, decim=1 ----
    do_reset();
    clear_mon();
    decim      = DIV_W'(1);
    pkt_len    = PKT_W'(512);
    flagn_full = 1'b0;
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    e0 = 0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (k == 0) e0 = cyc;
      if (k == 5) check("stall_slwrn_high", slwrn, 1);
      if (k == 10) begin
        check("stall_ovf", ovf_cnt, 9);
        flagn_full = 1'b1;
      end
      sample = 8'(8'hA0 + k);
      if (k == 0 || k >= 10) exp_q.push_back(sample);
      if (k == 14) run = 1'b0;
      @(posedge clk);
    end
    wait_idle(100);
    check("stall_first_wr_cycle", first_wr_cyc - e0, 11);
    check("stall_writes",   n_wr, 6);
    check("stall_ovf_final", ovf_cnt, 9);
    check("stall_pktend",   n_pkt, 1);

    // ---- decim shrinks 10 -> 3 while divider = 7 ----
    do_reset();
    clear_mon();
    decim      = DIV_W'(10);
    pkt_len    = PKT_W'(512);
    flagn_full = 1'b1;
    exp_gap    = 3;
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 17; k++) begin
      #1;
      if (k == 0) e0 = cyc;
      if (k == 7) decim = DIV_W'(3);
      sample = 8'(k * 13 + 1);
      if (k == 10 || k == 13 || k == 16) exp_q.push_back(sample);
      if (k == 16) run = 1'b0;
      @(posedge clk);
    end
    wait_idle(100);
    check("shrink_first_wr_cycle", first_wr_cyc - e0, 12);
    check("shrink_writes", n_wr, 3);
    check("shrink_gap",    gap_err, 0);
    check("shrink_q_empty", exp_q.size(), 0);

    // ---- async reset mid-packet with hold_valid=1 ----
    do_reset();
    clear_mon();
    decim      = DIV_W'(4);
    pkt_len    = PKT_W'(8);
    flagn_full = 1'b1;
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 17; k++) begin
      #1 sample = 8'(k * 29 + 7);
      if ((k % 4) == 3 && k < 12) exp_q.push_back(sample);
      if (k == 14) flagn_full = 1'b0;
      @(posedge clk);
    end
    check("prerst_writes", n_wr, 3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_fd",      fd, 0);
    check("arst_slwrn",   slwrn, 1);
    check("arst_pktendn", pktendn, 1);
    check("arst_busy",    busy, 0);
    check("arst_ovf",     ovf_cnt, 0);
    check("arst_state",   state_dbg, 0);
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    flagn_full = 1'b1;
    clear_mon();
    // a cleared byte_cnt makes 8 bytes exactly one auto-committed packet
    stream(1, 8, 8);
    wait_idle(100);
    check("postrst_writes", n_wr, 8);
    check("postrst_pktend", n_pkt, 0);
    check("postrst_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fx2_slavefifo_wr_ctrl.md
Name: fx2_slavefifo_wr_ctrl

Overview:
- Sequences the FX2LP slave-FIFO write path for the ADC stream.
- Divides IFCLK into a sample strobe and holds one sample while the FX2 FIFO is full.
- Counts bytes per packet, issues PKTENDN for short packets on stop, and counts dropped samples.
- Sits between the ADC capture register and the FD/SLWRN/PKTENDN pins; PIO registers from the SPI-to-Avalon core configure it.

Parameters:
- DIV_W, 26, width of the sample-rate divider.
- PKT_W, 10, width of the packet byte counter.
- OVF_W, 16, width of the saturating overflow counter.

Ports:
- clk  in  1  IFCLK (48 MHz), sole clock.
- reset_n  in  1  asynchronous active-low reset.
- run  in  1  stream enable (PIO bit, already synchronous to clk).
- decim  in  DIV_W  cycles per sample; 0 treated as 1.
- pkt_len  in  PKT_W  bytes per full packet (512 typical); 0 treated as 512.
- sample  in  8  registered ADC byte.
- flagn_full  in  1  FX2 FLAGN[1]: 1 = FIFO not full.
- fd  out  8  FX2 data bus.
- slwrn  out  1  FX2 write strobe, active-low.
- pktendn  out  1  FX2 packet end, active-low.
- sloen, slrdn  out  1 each  tied 1.
- fifoadr  out  2  tied 2'b00.
- busy  out  1  high in any state except IDLE.
- ovf_cnt  out  OVF_W  dropped samples, saturating.

Behaviour:
- Reset values: fd=0, slwrn=1, pktendn=1, busy=0, ovf_cnt=0, divider=0, byte_cnt=0, hold_valid=0, state=IDLE.
- Divider:
  - Counts 0..D-1, with D = max(decim,1).
  - strobe=1 in the cycle where divider==D-1.
  - If divider>=D-1 after decim shrinks, wrap to 0 next cycle.
  - Divider is held at 0 outside RUN.
- Holding register:
  - On strobe, if hold_valid=0: hold<=sample, hold_valid<=1.
  - On strobe with hold_valid=1 and no write this cycle: sample dropped; ovf_cnt+1, saturating at all-ones.
  - Write condition: hold_valid & flagn_full & state==RUN|DRAIN.
  - On a write: next cycle slwrn=0 for exactly 1 cycle, fd=hold, hold_valid clears, byte_cnt+1.
  - Latency from strobe to slwrn low is 2 cycles when not full.
  - Strobe coincident with a write: the new sample loads hold in the same edge (no drop).
- Packet counter: when byte_cnt reaches P-1 on a write (P = pkt_len, or 512 if 0), wrap to 0. The FX2 auto-commits full packets.
- States:
  - IDLE: run=1 -> RUN.
  - RUN: normal operation; run=0 -> DRAIN.
  - DRAIN: no new strobes; wait for hold_valid=0. Then byte_cnt!=0 -> GAP; byte_cnt==0 -> IDLE.
  - GAP: one idle cycle (slwrn=1) to meet the FX2 SLWR-to-PKTEND spacing -> PKTEND.
  - PKTEND: pktendn=0 for 1 cycle, byte_cnt<=0 -> IDLE.
  - run reasserted in DRAIN/GAP/PKTEND is ignored until IDLE is reached.
- slwrn and pktendn are never low in the same cycle.
- flagn_full=0 for an indefinite time stalls DRAIN indefinitely; this is legal.
- reset_n low mid-packet: immediate return to reset values. No PKTEND is issued; the partial packet stays in the FX2.
- All outputs are registered (no combinational path from inputs to pins).

Optional Feature:
- Macro: FX2_TEST_PATTERN_EN.
- Defined: hold loads an 8-bit ramp counter (reset 0, +1 per accepted strobe) instead of sample. Used for host-side gap/drop checking.
- Undefined: the ramp logic is absent and hold loads sample.

Decomposition:
- Package fx2_pkg holds:
  - state enum (IDLE, RUN, DRAIN, GAP, PKTEND);
  - FX2_PKT_DEFAULT=512;
  - FIFOADR_EP2=2'b00.
- One natural sub-module: fx2_rate_div (divider plus strobe, with the decim=0 and shrink rules).

Test Plan:
- decim=4, pkt_len=512, flagn_full=1, run=1 for 2048 strobes -> one slwrn pulse every 4 cycles, fd matches the sample captured 2 cycles earlier, ovf_cnt=0, no pktendn.
- decim=1, flagn_full=0 for 10 cycles mid-run -> hold keeps the first stalled byte, ovf_cnt=9, first write after release carries the held byte.
- run=1 for 100 strobes (decim=2), then run=0 -> 100 writes, 1 idle cycle, pktendn low 1 cycle, busy falls next cycle.
- run=0 after exactly 512 writes -> no pktendn, direct return to IDLE.
- decim=0 -> strobe every cycle. Change decim 10->3 while divider=7 -> divider wraps to 0 next cycle, then period 3.
- reset_n pulsed low mid-packet with hold_valid=1 -> all outputs at reset values asynchronously, byte_cnt=0. With FX2_TEST_PATTERN_EN defined, the ramp restarts at 0x00.
